instr_fetch: RTL and testbench

//  Instruction fetch front-end: owns the PC and drives the imem combinational read port.

---
 rtl/core_pkg.sv | 14 +
 rtl/instr_fetch_if.sv | 11 +
 rtl/instr_fetch_fifo.sv | 43 ++++
 rtl/instr_fetch.sv | 71 +++++++
 tb/tb_instr_fetch.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core types: fetch entry record, NOP encoding and PC alignment helper.
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch -> decode valid/ready handshake carrying the {pc, instruction} head.
interface instr_fetch_if;
  import core_pkg::*;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;

  modport master (output if_valid, output if_instr, output if_pc, input if_ready);
  modport slave  (input if_valid, input if_instr, input if_pc, output if_ready);
endinterface

// File: rtl/instr_fetch_fifo.sv
// Synchronous prefetch FIFO with flush; pointers wrap naturally at DEPTH (power of 2).
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [63:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  T                       din,
  output T                       head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front-end: PC, imem read, prefetch FIFO, redirect flush.
// Optional IFETCH_STATS_EN adds saturating fetched/flushed counters.
module instr_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  instr_fetch_if.master   dec
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]     stat_fetched,
  output logic [31:0]     stat_flushed
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   count;
  fetch_entry_t    head, wr_entry;
  logic            has, push, pop;

  assign has          = (count != '0);
  assign dec.if_valid = has & ~redirect_valid;
  assign pop          = dec.if_valid & dec.if_ready;
  // A full FIFO may still accept when the head leaves in the same cycle.
  assign push         = fetch_en & ~redirect_valid & ((count < CW'(DEPTH)) | pop);
  assign dec.if_instr = has ? head.instr : NOP_INSTR;
  assign dec.if_pc    = has ? head.pc    : pc_q;
  assign imem_addr    = pc_q;
  assign wr_entry     = '{pc: pc_q, instr: imem_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pc_q <= RESET_PC;
    else if (redirect_valid) pc_q <= align_pc(redirect_pc);
    else if (push)           pc_q <= pc_q + 32'd4;
  end

  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (wr_entry),
    .head  (head),
    .count (count)
  );

`ifdef IFETCH_STATS_EN
  logic [32:0] flush_sum;
  assign flush_sum = {1'b0, stat_flushed} + 33'(count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      if (pop && stat_fetched != '1) stat_fetched <= stat_fetched + 32'd1;
      if (redirect_valid) stat_flushed <= flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, async-reset/drain sequences, random vs queue model.
module tb_instr_fetch;
  import core_pkg::*;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_en = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0, imem_addr, imem_rdata;
  logic [31:0] w_addr, w_rdata;
`ifdef IFETCH_STATS_EN
  logic [31:0] stat_fetched, stat_flushed, w_fetched, w_flushed;
`endif

  instr_fetch_if dif();
  instr_fetch_if wif();

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'd17;
  endfunction

  assign imem_rdata   = mem_word(imem_addr);
  assign w_rdata      = mem_word(w_addr);
  assign wif.if_ready = 1'b1;

  instr_fetch #(.RESET_PC(32'h0), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec(dif)
`ifdef IFETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .dec(wif)
`ifdef IFETCH_STATS_EN
    , .stat_fetched(w_fetched), .stat_flushed(w_flushed)
`endif
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference model: a plain queue of {pc, instr} plus the next fetch address.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic [31:0] mpc, m_fetched, m_flushed;

  task automatic model_reset(input logic [31:0] rpc);
    mq.delete();
    mpc = rpc; m_fetched = 0; m_flushed = 0;
  endtask

  task automatic step(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy,
                      input bit use_exp, input logic ev, input logic [31:0] epc,
                      input logic [31:0] ein, input string tag);
    logic        mv, mpop;
    logic [31:0] mp, mi;
    ent_t        e;
    fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; dif.if_ready = rdy;
    @(negedge clk);
    mp = mpc; mi = NOP_INSTR;
    if (mq.size() != 0) begin mp = mq[0].pc; mi = mq[0].instr; end
    mv = (mq.size() != 0) && !rv;
    if (use_exp) begin
      chk({tag, " valid"}, {31'b0, dif.if_valid}, {31'b0, ev});
      chk({tag, " pc"}, dif.if_pc, epc);
      chk({tag, " instr"}, dif.if_instr, ein);
    end else begin
      chk({tag, " valid"}, {31'b0, dif.if_valid}, {31'b0, mv});
      chk({tag, " pc"}, dif.if_pc, mp);
      chk({tag, " instr"}, dif.if_instr, mi);
    end
    chk({tag, " imem_addr"}, imem_addr, mpc);
    mpop = mv && rdy;
    if (rv) begin
      m_flushed = (m_flushed + mq.size() < m_flushed) ? 32'hFFFF_FFFF : m_flushed + mq.size();
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else begin
      if (mpop) begin
        void'(mq.pop_front());
        if (m_fetched != 32'hFFFF_FFFF) m_fetched++;
      end
      if (fe && (mq.size() < DEPTH)) begin
        e.pc = mpc; e.instr = mem_word(mpc);
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fetch_en = 0; redirect_valid = 0; dif.if_ready = 0;
    @(posedge clk); #1;
    chk("rst valid", {31'b0, dif.if_valid}, 32'h0);
    chk("rst pc", dif.if_pc, 32'h0);
    chk("rst instr", dif.if_instr, NOP_INSTR);
    chk("rst imem_addr", imem_addr, 32'h0);
    chk("rst wrap pc", wif.if_pc, 32'hFFFF_FFF8);
`ifdef IFETCH_STATS_EN
    chk("rst stat_fetched", stat_fetched, 32'h0);
    chk("rst stat_flushed", stat_flushed, 32'h0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset(32'h0);
  endtask

  typedef struct {
    logic fe; logic rv; logic [31:0] rpc; logic rdy;
    logic ev; logic [31:0] epc; logic [31:0] ein;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(input logic fe, input logic rv, input logic [31:0] rpc,
                              input logic rdy, input logic ev, input logic [31:0] epc,
                              input logic [31:0] ein);
    vec_t v;
    v.fe = fe; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev; v.epc = epc; v.ein = ein;
    return v;
  endfunction

  initial begin
    logic [31:0] wexp [3];
    logic        fe, rv, rdy;
    logic [31:0] rpc;
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0;

    // Fill with decode stalled, release into a continuous stream, then redirects.
    tv.push_back(mk(1, 0, 0, 0, 0, 32'h0, NOP_INSTR));
    for (int k = 0; k < 9; k++) tv.push_back(mk(1, 0, 0, 0, 1, 32'h0, 32'h11));
    tv.push_back(mk(1, 0, 0, 1, 1, 32'h0,   32'h11));
    tv.push_back(mk(1, 0, 0, 1, 1, 32'h4,   32'h22));
    tv.push_back(mk(1, 0, 0, 1, 1, 32'h8,   32'h33));
    tv.push_back(mk(1, 0, 0, 1, 1, 32'hC,   32'h44));
    tv.push_back(mk(1, 0, 0, 1, 1, 32'h10,  32'h55));
    tv.push_back(mk(0, 0, 0, 1, 1, 32'h14,  32'h66));
    tv.push_back(mk(1, 1, 32'h103, 1, 0, 32'h18, 32'h77));
    tv.push_back(mk(1, 0, 0, 1, 0, 32'h100, NOP_INSTR));
    tv.push_back(mk(1, 0, 0, 1, 1, 32'h100, 32'h451));
    tv.push_back(mk(1, 0, 0, 1, 1, 32'h104, 32'h462));
    tv.push_back(mk(1, 1, 32'h200, 1, 0, 32'h108, 32'h473));
    tv.push_back(mk(1, 1, 32'h300, 1, 0, 32'h200, NOP_INSTR));
    tv.push_back(mk(1, 0, 0, 1, 0, 32'h300, NOP_INSTR));
    tv.push_back(mk(1, 0, 0, 1, 1, 32'h300, 32'hCD1));

    do_reset();
    foreach (tv[i]) begin
      step(tv[i].fe, tv[i].rv, tv[i].rpc, tv[i].rdy, 1'b1, tv[i].ev, tv[i].epc, tv[i].ein,
           $sformatf("vec%0d", i));
      if (i < 3) begin
        chk($sformatf("wrap%0d pc", i), wif.if_pc, wexp[i]);
        chk($sformatf("wrap%0d valid", i), {31'b0, wif.if_valid}, 32'h1);
      end
    end
`ifdef IFETCH_STATS_EN
    chk("vec stat_fetched", stat_fetched, 32'd9);
    chk("vec stat_flushed", stat_flushed, 32'd4);
`endif

    // Async reset in the middle of a full FIFO.
    for (int k = 0; k < 6; k++) step(1, 0, 0, 0, 1'b0, 0, 0, 0, "fill");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst valid", {31'b0, dif.if_valid}, 32'h0);
    chk("async_rst imem_addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset(32'h0);
    for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 1'b0, 0, 0, 0, "refill");
    for (int k = 0; k < 6; k++) step(0, 0, 0, 1, 1'b0, 0, 0, 0, "drain");
    chk("drained valid", {31'b0, dif.if_valid}, 32'h0);
    chk("drained pc frozen", imem_addr, 32'h10);

    // Random traffic against the queue model.
    for (int k = 0; k < 800; k++) begin
      rv  = ($urandom % 12) == 0;
      fe  = ($urandom % 4) != 0;
      rdy = ($urandom % 3) != 0;
      rpc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      step(fe, rv, rpc, rdy, 1'b0, 0, 0, 0, "rand");
    end
`ifdef IFETCH_STATS_EN
    chk("rand stat_fetched", stat_fetched, m_fetched);
    chk("rand stat_flushed", stat_flushed, m_flushed);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
